fixed_rsqrt_unit: RTL

FIXED_RSQRT_UNIT -- requirements
Module: fixed_rsqrt_unit

---
 rtl/fixed_rsqrt_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fixed_rsqrt_unit.sv
// Pipelined fixed-point reciprocal square root / square root.
// A table seed is refined by Newton iterations; domain cases ride the same pipe.
module fixed_rsqrt_unit #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 15,
  parameter int ITERS = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int L  = 3 * ITERS + 2;
  localparam int LW = $clog2(WIDTH);

  typedef logic signed [WIDTH-1:0] word_t;

  localparam word_t MAXV  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam word_t HALF3 = {{(WIDTH-2){1'b0}}, 2'b11} << (FRAC - 1);

  function automatic word_t fmul(input word_t a, input word_t b);
    logic signed [2*WIDTH-1:0] prod;
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    prod = prod >>> FRAC;
    fmul = prod[WIDTH-1:0];
  endfunction

  // Seed for a leading one at bit p: x ~ 2^(p-FRAC), so 1/sqrt(x) ~ 2^((FRAC-p)/2).
  function automatic word_t seed_of(input int p);
    real r;
    r = 2.0 ** (real'(FRAC) + (real'(FRAC) - real'(p)) / 2.0);
    if (r + 0.5 >= 2.0 ** (WIDTH - 1) - 1.0) seed_of = MAXV;
    else seed_of = word_t'(longint'(r));
  endfunction

  word_t seed_tab [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_seed
    localparam word_t SEED_VAL = seed_of(g);
    assign seed_tab[g] = SEED_VAL;
  end

  logic          vld_r [L];
  logic          md_r  [L];
  logic          err_r [L];
  word_t         x_r   [L];
  word_t         y_r   [L];
  word_t         t_r   [L];

  logic          n_vld [L];
  logic          n_md  [L];
  logic          n_err [L];
  word_t         n_x   [L];
  word_t         n_y   [L];
  word_t         n_t   [L];

  logic [LW-1:0] lead_s;
  logic          pos_s;
  logic          advance_s;

  assign advance_s = !vld_r[L-1] || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = vld_r[L-1];
  assign out_data  = y_r[L-1];
  assign out_err   = err_r[L-1];

  // leading-one position of the incoming operand
  always_comb begin
    lead_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) lead_s = i[LW-1:0];
      else lead_s = lead_s;
    end
  end

  assign pos_s = !in_data[WIDTH-1] && (in_data != '0);

  // next-state of every stage: seed, Newton steps, then final result select
  always_comb begin
    n_vld[0] = in_valid;
    n_md[0]  = in_mode;
    n_x[0]   = in_data;
    n_t[0]   = '0;
    n_err[0] = in_data[WIDTH-1] | ((in_data == '0) & ~in_mode);
    // non-positive operands carry y = 0 so sqrt(0) falls out of x*y naturally
    if (pos_s) n_y[0] = seed_tab[lead_s];
    else n_y[0] = '0;

    for (int s = 1; s < L; s++) begin
      n_vld[s] = vld_r[s-1];
      n_md[s]  = md_r[s-1];
      n_err[s] = err_r[s-1];
      n_x[s]   = x_r[s-1];
      n_y[s]   = y_r[s-1];
      n_t[s]   = t_r[s-1];
      if (s == L - 1) begin
        if (err_r[s-1]) begin
          if (x_r[s-1] == '0) n_y[s] = MAXV;
          else n_y[s] = '0;
        end else if (md_r[s-1]) begin
          n_y[s] = fmul(x_r[s-1], y_r[s-1]);
        end else begin
          n_y[s] = y_r[s-1];
        end
      end else if ((s - 1) % 3 == 0) begin
        n_t[s] = fmul(y_r[s-1], y_r[s-1]);
      end else if ((s - 1) % 3 == 1) begin
        n_t[s] = fmul(x_r[s-1] >>> 1, t_r[s-1]);
      end else begin
        n_y[s] = fmul(y_r[s-1], HALF3 - t_r[s-1]);
      end
    end
  end

  // pipeline registers: global stall, synchronous clear
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < L; s++) begin
        vld_r[s] <= 1'b0;
        md_r[s]  <= 1'b0;
        err_r[s] <= 1'b0;
        x_r[s]   <= '0;
        y_r[s]   <= '0;
        t_r[s]   <= '0;
      end
    end else if (advance_s) begin
      for (int s = 0; s < L; s++) begin
        vld_r[s] <= n_vld[s];
        md_r[s]  <= n_md[s];
        err_r[s] <= n_err[s];
        x_r[s]   <= n_x[s];
        y_r[s]   <= n_y[s];
        t_r[s]   <= n_t[s];
      end
    end
  end

endmodule
